weight_tile_scheduler: RTL and testbench

Sequences the weight-BRAM read controller across the tiles of one transposed-convolution layer. Per tile, it issues a start pulse and a 9-bit address window to the controller, waits for the controller's done, and then waits for the PE array to accept the next tile. It sits between the layer-level control FSM and the 16-bank weight BRAM controller, and owns all weight address windowing for a layer.

---
 rtl/weight_sched_pkg.sv | 16 +
 rtl/wts_watchdog.sv | 24 ++
 rtl/weight_tile_scheduler.sv | 122 ++++++++++++
 tb/tb_weight_tile_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_sched_pkg.sv
// Shared types and constants for the weight tile scheduler.
package weight_sched_pkg;

    localparam int WTS_ADDR_W = 9;
    localparam int WTS_TILE_W = 5;
    localparam int BRAM_DEPTH = 512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_PE,
        S_FINISH
    } wts_state_e;

endpackage

// File: rtl/wts_watchdog.sv
// Cycle counter for WAIT_DONE; expired fires on the LIMIT-th enabled cycle after clr.
module wts_watchdog #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + CW'(1);
    end

    assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/weight_tile_scheduler.sv
// Walks one layer's weight tiles, issuing address windows to the BRAM read controller.
// Optional WAIT_DONE watchdog enabled by defining WTS_TIMEOUT_EN.
module weight_tile_scheduler
    import weight_sched_pkg::*;
#(
    parameter int ADDR_W  = WTS_ADDR_W,
    parameter int TILE_W  = WTS_TILE_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] tile_len,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              pe_ready,
    input  logic              ctrl_done,
    output logic              ctrl_start,
    output logic [ADDR_W-1:0] ctrl_addr_start,
    output logic [ADDR_W-1:0] ctrl_addr_end,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              layer_done,
    output logic              err
);

    wts_state_e        state;
    logic [ADDR_W:0]   cur_addr;   // one extra bit so the address past the BRAM end is visible
    logic [ADDR_W-1:0] len_q;
    logic [TILE_W-1:0] num_q;
    logic [ADDR_W:0]   end_addr;

    assign end_addr = cur_addr + {1'b0, len_q} - (ADDR_W+1)'(1);

`ifdef WTS_TIMEOUT_EN
    logic wd_expired;

    wts_watchdog #(.LIMIT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == S_ISSUE),
        .en      (state == S_WAIT_DONE),
        .expired (wd_expired)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cur_addr        <= '0;
            len_q           <= '0;
            num_q           <= '0;
            ctrl_start      <= 1'b0;
            ctrl_addr_start <= '0;
            ctrl_addr_end   <= '0;
            tile_idx        <= '0;
            busy            <= 1'b0;
            layer_done      <= 1'b0;
            err             <= 1'b0;
        end else begin
            ctrl_start <= 1'b0;
            layer_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (layer_start) begin
                        len_q    <= tile_len;
                        num_q    <= num_tiles;
                        cur_addr <= {1'b0, base_addr};
                        tile_idx <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (num_tiles == '0 || tile_len == '0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (end_addr[ADDR_W]) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ctrl_addr_start <= cur_addr[ADDR_W-1:0];
                        ctrl_addr_end   <= end_addr[ADDR_W-1:0];
                        ctrl_start      <= 1'b1;
                        state           <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (ctrl_done) begin
                        cur_addr <= {1'b0, ctrl_addr_end} + (ADDR_W+1)'(1);
                        if (tile_idx == num_q - TILE_W'(1)) begin
                            state <= S_FINISH;
                        end else begin
                            tile_idx <= tile_idx + TILE_W'(1);
                            state    <= S_WAIT_PE;
                        end
                    end
`ifdef WTS_TIMEOUT_EN
                    else if (wd_expired) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
`endif
                end
                S_WAIT_PE: begin
                    if (pe_ready) state <= S_ISSUE;
                end
                S_FINISH: begin
                    // busy stays up here and drops one cycle after the done pulse
                    layer_done <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Self-checking bench for weight_tile_scheduler: vector table, timing sequences, random layers.
module tb_weight_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       layer_start;
    logic [8:0] base_addr, tile_len;
    logic [4:0] num_tiles;
    logic       pe_ready, ctrl_done;
    logic       ctrl_start;
    logic [8:0] ctrl_addr_start, ctrl_addr_end;
    logic [4:0] tile_idx;
    logic       busy, layer_done, err;

    logic pe_man = 1'b1, pe_rand = 1'b0, pe_rnd_val = 1'b1;
    logic resp_done = 1'b0, spur_done = 1'b0, withhold = 1'b0;
    int   done_delay = 5, cd = 0;

    assign pe_ready  = pe_rand ? pe_rnd_val : pe_man;
    assign ctrl_done = resp_done | spur_done;

    always #5 clk = ~clk;

    weight_tile_scheduler #(.TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n), .layer_start(layer_start), .base_addr(base_addr),
        .tile_len(tile_len), .num_tiles(num_tiles), .pe_ready(pe_ready), .ctrl_done(ctrl_done),
        .ctrl_start(ctrl_start), .ctrl_addr_start(ctrl_addr_start), .ctrl_addr_end(ctrl_addr_end),
        .tile_idx(tile_idx), .busy(busy), .layer_done(layer_done), .err(err)
    );

    typedef struct { int s; int e; int idx; } win_t;
    typedef struct { int b; int l; int t; int d; int n_win; int err; int done; } vec_t;

    win_t got[$];
    win_t exp_w[$];
    int   exp_err;
    int   done_cnt = 0;
    int   got_base, done_base;
    int   n_cmp = 0, n_bad = 0;

    // Monitor plus controller model: answers each start with a done after done_delay cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            cd = 0;
            resp_done = 1'b0;
        end else begin
            if (cd > 0) begin
                cd = cd - 1;
                resp_done = (cd == 0);
            end else begin
                resp_done = 1'b0;
            end
            if (ctrl_start) begin
                got.push_back('{int'(ctrl_addr_start), int'(ctrl_addr_end), int'(tile_idx)});
                if (!withhold) cd = done_delay;
            end
            if (layer_done) done_cnt++;
            pe_rnd_val = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference: tiles laid end to end from base; stop with error once a window passes 511.
    task automatic build_model(input int b, input int l, input int t);
        int cur;
        exp_w.delete();
        exp_err = 0;
        cur = b;
        if (l != 0) begin
            for (int i = 0; i < t; i++) begin
                if (cur + l - 1 > 511) begin
                    exp_err = 1;
                    break;
                end
                exp_w.push_back('{cur, cur + l - 1, i});
                cur = cur + l;
            end
        end
    endtask

    task automatic start_layer(input int b, input int l, input int t);
        @(negedge clk);
        base_addr   = 9'(b);
        tile_len    = 9'(l);
        num_tiles   = 5'(t);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
        chk({tag, "_idle"}, int'(busy), 0);
        @(negedge clk);
    endtask

    task automatic run_layer(input int b, input int l, input int t, input int d);
        got_base   = got.size();
        done_base  = done_cnt;
        done_delay = d;
        start_layer(b, l, t);
        wait_idle("run");
    endtask

    task automatic check_layer(input string tag);
        int n;
        n = got.size() - got_base;
        chk({tag, "_nwin"}, n, exp_w.size());
        for (int i = 0; i < exp_w.size() && i < n; i++) begin
            chk({tag, "_ws"}, got[got_base+i].s, exp_w[i].s);
            chk({tag, "_we"}, got[got_base+i].e, exp_w[i].e);
            chk({tag, "_wi"}, got[got_base+i].idx, exp_w[i].idx);
        end
        chk({tag, "_err"}, int'(err), exp_err);
        chk({tag, "_done"}, done_cnt - done_base, exp_err ? 0 : 1);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{128, 32,  4, 5,  4, 0, 1};
        vecs[1] = '{480, 16,  3, 3,  2, 1, 0};
        vecs[2] = '{  0,  0,  5, 2,  0, 0, 1};
        vecs[3] = '{100, 10,  0, 2,  0, 0, 1};
        vecs[4] = '{  0, 511, 2, 2,  1, 1, 0};
        vecs[5] = '{500, 12,  1, 1,  1, 0, 1};
        vecs[6] = '{511,  1, 31, 1,  1, 1, 0};
        vecs[7] = '{  1, 511, 1, 4,  1, 0, 1};
        vecs[8] = '{300,  1, 20, 1, 20, 0, 1};

        rst_n = 1'b0; layer_start = 1'b0; base_addr = '0; tile_len = '0; num_tiles = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_start", int'(ctrl_start), 0);
        chk("rst_as", int'(ctrl_addr_start), 0);
        chk("rst_ae", int'(ctrl_addr_end), 0);
        chk("rst_idx", int'(tile_idx), 0);
        chk("rst_done", int'(layer_done), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table
        foreach (vecs[i]) begin
            run_layer(vecs[i].b, vecs[i].l, vecs[i].t, vecs[i].d);
            chk("vec_nwin", got.size() - got_base, vecs[i].n_win);
            chk("vec_err", int'(err), vecs[i].err);
            chk("vec_done", done_cnt - done_base, vecs[i].done);
            build_model(vecs[i].b, vecs[i].l, vecs[i].t);
            check_layer("vec");
        end

        // Start and last-tile latency with a hand-driven done
        withhold = 1'b1;
        start_layer(128, 32, 1);
        chk("lat_busy", int'(busy), 1);
        chk("lat_nostart", int'(ctrl_start), 0);
        @(negedge clk);
        chk("lat_start", int'(ctrl_start), 1);
        chk("lat_as", int'(ctrl_addr_start), 128);
        chk("lat_ae", int'(ctrl_addr_end), 159);
        repeat (3) @(negedge clk);
        chk("lat_hold_ae", int'(ctrl_addr_end), 159);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("lat_m0_done", int'(layer_done), 0);
        chk("lat_m0_busy", int'(busy), 1);
        @(negedge clk);
        chk("lat_m1_done", int'(layer_done), 1);
        chk("lat_m1_busy", int'(busy), 1);
        @(negedge clk);
        chk("lat_m2_done", int'(layer_done), 0);
        chk("lat_m2_busy", int'(busy), 0);
        withhold = 1'b0;

        // Degenerate layer timing
        got_base = got.size();
        start_layer(40, 0, 3);
        chk("deg_busy", int'(busy), 1);
        chk("deg_d0", int'(layer_done), 0);
        @(negedge clk);
        chk("deg_d1", int'(layer_done), 1);
        chk("deg_err", int'(err), 0);
        wait_idle("deg");
        chk("deg_nostart", got.size() - got_base, 0);

        // Backpressure: pe_ready low for 20 cycles after tile 0 completes
        pe_man = 1'b0;
        got_base = got.size(); done_base = done_cnt; done_delay = 5;
        start_layer(128, 32, 2);
        for (int k = 0; k < 200 && !ctrl_done; k++) @(negedge clk);
        chk("bp_done_seen", int'(ctrl_done), 1);
        begin
            int starts = 0;
            repeat (20) begin
                @(negedge clk);
                if (ctrl_start) starts++;
            end
            chk("bp_nostart", starts, 0);
        end
        chk("bp_idx", int'(tile_idx), 1);
        pe_man = 1'b1;
        @(negedge clk);
        chk("bp_s0", int'(ctrl_start), 0);
        @(negedge clk);
        chk("bp_s1", int'(ctrl_start), 1);
        chk("bp_as", int'(ctrl_addr_start), 160);
        wait_idle("bp");
        build_model(128, 32, 2);
        check_layer("bp");

        // Mid-layer layer_start and a spurious done in WAIT_PE are ignored
        pe_man = 1'b0;
        got_base = got.size(); done_base = done_cnt; done_delay = 4;
        start_layer(64, 40, 3);
        for (int k = 0; k < 200 && !ctrl_done; k++) @(negedge clk);
        @(negedge clk);
        spur_done = 1'b1; layer_start = 1'b1; base_addr = 9'd0; tile_len = 9'd5; num_tiles = 5'd1;
        @(negedge clk);
        spur_done = 1'b0; layer_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rob_idx", int'(tile_idx), 1);
        pe_man = 1'b1;
        wait_idle("rob");
        build_model(64, 40, 3);
        check_layer("rob");

        // Asynchronous reset in WAIT_DONE
        withhold = 1'b1;
        start_layer(10, 20, 2);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", int'(busy), 0);
        chk("ar_as", int'(ctrl_addr_start), 0);
        chk("ar_ae", int'(ctrl_addr_end), 0);
        chk("ar_idx", int'(tile_idx), 0);
        chk("ar_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        withhold = 1'b0;
        run_layer(200, 30, 3, 2);
        build_model(200, 30, 3);
        check_layer("ar");

`ifdef WTS_TIMEOUT_EN
        withhold = 1'b1;
        done_base = done_cnt;
        start_layer(0, 8, 2);
        @(negedge clk);
        chk("to_start", int'(ctrl_start), 1);
        begin
            int k;
            for (k = 0; k < 200 && !err; k++) @(negedge clk);
            chk("to_cycles", k, 50);
        end
        chk("to_busy", int'(busy), 0);
        @(negedge clk);
        chk("to_nodone", done_cnt - done_base, 0);
        withhold = 1'b0;
`endif

        // Random layers with random PE backpressure
        pe_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            int b, l, t, d;
            b = $urandom_range(0, 511);
            l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80);
            t = $urandom_range(0, 12);
            d = $urandom_range(1, 6);
            run_layer(b, l, t, d);
            build_model(b, l, t);
            check_layer("rnd");
        end
        pe_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
